xor_parity_rx: RTL

- Serial frame receiver and parity checker. It is the receiving end of the XOR-based parity-generating serial link.
- Captures one start bit, DATA_W data bits (LSB first), one parity bit and one stop bit, sampled on bit strobes.
- Recomputes parity with a running XOR and presents the byte plus error flags on a valid/ready output interface.
- Sits between the line bit-synchroniser (which produces the strobes) and the consuming datapath.

---
 rtl/xor_parity_pkg.sv | 19 +
 rtl/xor_parity_acc.sv | 41 ++++
 rtl/xor_parity_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/xor_parity_pkg.sv
// xor_parity_pkg: shared types and constants for the XOR-parity serial link
// (receiver now, transmitter later).
//   rx_state_t : receiver frame-tracking states
//   PAR_EVEN / PAR_ODD : accumulator seeds for even / odd parity
//   LINE_IDLE  : idle (and valid stop-bit) level of the serial line
package xor_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/xor_parity_acc.sv
// xor_parity_acc: 1-bit running XOR accumulator.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears the accumulator
//   load_i : load seed_i (takes priority over en_i)
//   seed_i : value loaded at the start of a frame (parity seed)
//   en_i   : fold bit_i into the accumulator this cycle
//   bit_i  : bit to fold in
//   acc_o  : current accumulator value
module xor_parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic seed_i,
  input  logic en_i,
  input  logic bit_i,
  output logic acc_o
);

  logic acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = seed_i;
    end else if (en_i) begin
      acc_d = acc_q ^ bit_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/xor_parity_rx.sv
// xor_parity_rx: serial frame receiver and parity checker.
// Frame: start(0), DATA_W data bits LSB first, parity, stop(1); each bit is
// taken only on a bit_valid strobe. The completed word and its error flags
// are offered on a valid/ready interface.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   bit_in      : serial line value (idle 1)
//   bit_valid   : one-cycle sample strobe for bit_in
//   data_out    : received word
//   out_valid   : data_out/flags valid, held until out_ready
//   out_ready   : consumer accept
//   parity_err  : parity mismatch for the presented word
//   frame_err   : stop bit was 0 for the presented word
//   overrun     : sticky, a frame was dropped because the output was full
//   err_count   : (only with XOR_PARITY_RX_ERRCNT_EN) saturating count of
//                 delivered frames carrying a parity or framing error
// Optional feature macro: XOR_PARITY_RX_ERRCNT_EN.
module xor_parity_rx
  import xor_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
`ifdef XOR_PARITY_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic SEED = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              mismatch_q, mismatch_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovld_q, ovld_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic acc_load, acc_en, acc;
  logic frame_done;
  // Output slot is free if empty or being emptied this very cycle.
  logic slot_free;

  xor_parity_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .load_i (acc_load),
    .seed_i (SEED),
    .en_i   (acc_en),
    .bit_i  (bit_in),
    .acc_o  (acc)
  );

  assign slot_free = ~ovld_q | out_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    mismatch_d = mismatch_q;
    acc_load   = 1'b0;
    acc_en     = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (bit_valid && (bit_in != LINE_IDLE)) begin
          acc_load = 1'b1;
          cnt_d    = '0;
          shift_d  = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_valid) begin
          acc_en = 1'b1;
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              shift_d[i] = bit_in;
            end
          end
          if (cnt_q == LAST_IDX) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          // acc already holds seed ^ data; folding in the parity bit gives
          // 0 for a correct frame in either parity mode.
          mismatch_d = acc ^ bit_in;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_valid) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    ovld_d = ovld_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (frame_done) begin
      if (slot_free) begin
        dout_d = shift_q;
        perr_d = mismatch_q;
        ferr_d = (bit_in != LINE_IDLE);
        ovld_d = 1'b1;
      end else begin
        // Keep the unaccepted word; the new one is lost.
        ovr_d = 1'b1;
      end
    end else if (ovld_q && out_ready) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      mismatch_q <= 1'b0;
      dout_q     <= '0;
      ovld_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mismatch_q <= mismatch_d;
      dout_q     <= dout_d;
      ovld_q     <= ovld_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign out_valid  = ovld_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

`ifdef XOR_PARITY_RX_ERRCNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    // Only frames that actually reach the output are counted.
    if (frame_done && slot_free && (mismatch_q || (bit_in != LINE_IDLE)) &&
        (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ecnt_q <= 8'd0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_count = ecnt_q;
`endif

endmodule
